scancode_stream_decoder: RTL and testbench
==========================================

# scancode_stream_decoder

Parametrised successor to `scandecoder`: consumes the PS/2 Set-2 byte stream from the keyboard receiver and decodes it into key events. It tracks E0/F0 prefixes and shift state, and queues decoded events in a small first-word-fall-through FIFO with a valid/ready output handshake. It sits between the PS/2 byte receiver and the character/display logic.

## Interface
- `DATA_W`, default 6: key-code width; must be ≥6, codes are zero-extended above bit 5.
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and ≥2.
- `EMIT_BREAK`, default 0: 0 = queue make events only; 1 = also queue break events, with `out_break`=1.
- `clock` input, 1 bit: single clock, all logic on the rising edge.
- `reset_n` input, 1 bit: synchronous, active-low reset.
- `code_valid` input, 1 bit: `code` carries a received byte this cycle.
- `code` input, 8 bits: raw scan byte.
- `out_valid` output, 1 bit: FIFO head is valid.
- `out_ready` input, 1 bit: consumer accepts the head this cycle.
- `out_data` output, DATA_W bits: key code of the head entry.
- `out_break` output, 1 bit: head is a release (break) event.
- `out_ext` output, 1 bit: head was E0-prefixed.
- `out_shift` output, 1 bit: either shift key was held when the event was decoded.
- `overflow` output, 1 bit: sticky; an event was dropped because the FIFO was full.
- `unknown` output, 1 bit: one-cycle pulse; an unmapped code was dropped.

## Operation
- Prefix FSM, advanced only on cycles with `code_valid`=1. States: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0→EXT, F0→BRK.
  - EXT: F0→EXT_BRK.
  - BRK and EXT_BRK: an F0 byte keeps the current state.
  - Any E0 byte goes to EXT from any state.
  - Any other byte is a key byte. It is decoded with ext = (state ∈ {EXT, EXT_BRK}) and brk = (state ∈ {BRK, EXT_BRK}). The FSM then returns to IDLE.
- Bytes AA, FA, FE, EE and 00 are ignored. They return the FSM to IDLE, produce no event and do not pulse `unknown`.
- Shift tracking:
  - Key 12 (left) or 59 (right) without E0: make sets the matching shift bit, break clears it.
  - Shift keys never generate FIFO events.
  - `out_shift` for an event is the OR of both shift bits before the current byte is applied.
- Key map (Set 2 hex → code). Code 0 is never emitted.
  - Letters: A 1C=1, B 32=2, C 21=3, D 23=4, E 24=5, F 2B=6, G 34=7, H 33=8, I 43=9, J 3B=10, K 42=11, L 4B=12, M 3A=13, N 31=14, O 44=15, P 4D=16, Q 15=17, R 2D=18, S 1B=19, T 2C=20, U 3C=21, V 2A=22, W 1D=23, X 22=24, Y 35=25, Z 1A=26.
  - Digits: 0 45=27, 1 16=28, 2 1E=29, 3 26=30, 4 25=31, 5 2E=32, 6 36=33, 7 3D=34, 8 3E=35, 9 46=36.
  - Others: space 29=37, enter 5A=38 (also valid with E0, i.e. keypad enter), backspace 66=39.
  - With E0, only 5A is mapped. Every other E0-prefixed key byte is unmapped.
- Unmapped key byte: no event, `unknown` pulses, FSM returns to IDLE.
- Event push happens when the byte is mapped and (brk=0 or EXT_BRK... or EMIT_BREAK=1). Stated plainly: a mapped make always pushes; a mapped break pushes only when EMIT_BREAK=1.
- FIFO entry is {brk, ext, shift, code}.
  - Pop occurs on `out_valid && out_ready`.
  - Push while full with no pop in the same cycle: the new entry is dropped and `overflow` is set.
  - Push while full with a pop in the same cycle: accepted.
  - Push while empty: entry appears at the head on the next cycle.
- `overflow` clears only on reset.

## Timing
- Reset values: state IDLE, both shift bits 0, FIFO empty, `out_valid`=0, `out_data`/`out_break`/`out_ext`/`out_shift`=0, `overflow`=0, `unknown`=0.
- Reset mid-sequence (e.g. after E0 or F0) discards the pending prefix.
- Latency: a key byte accepted in cycle N makes `out_valid`=1 in cycle N+1 when the FIFO was empty.
- `unknown` is asserted in cycle N+1 for exactly 1 cycle.
- `out_*` are registered. They remain stable while `out_valid && !out_ready`.
- Throughput: one accepted byte and one pop per cycle, sustained. Back-to-back `code_valid` is legal.
- Occupancy after a cycle is count + push − pop. Pop on empty is ignored.

## Test plan
- Reset, then bytes 1C and 1B on consecutive cycles → two events, `out_data`=1 then 19, break=0, ext=0, shift=0. The first event is valid 1 cycle after 1C.
- Byte sequence 12, 1C, F0, 1C, F0, 12, 1C with EMIT_BREAK=0 → events 1/shift=1 then 1/shift=0. No break events are queued.
- EMIT_BREAK=1, bytes E0, 5A, E0, F0, 5A → events 38/ext=1/break=0 then 38/ext=1/break=1. E0 then 75 → no event and an `unknown` pulse.
- DEPTH=4, `out_ready`=0, six make bytes of 1C → exactly 4 entries held and `overflow`=1. A simultaneous push and pop when full keeps 4 entries and the new entry is accepted.
- Bytes F0 then reset_n=0 for 1 cycle, then 1C → make event 1 (prefix discarded).
- Bytes AA, FA, 00 interleaved with 1C → only event 1, no `unknown` pulse.

Source files
------------

// File: rtl/scancode_stream_decoder.sv
// PS/2 Set-2 byte stream to key-event decoder feeding a first-word-fall-through event FIFO.
// An event is visible one cycle after its key byte; a full FIFO drops new events (sticky overflow) unless popped that cycle.

module scancode_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign head_vld = (count != '0);
  assign full     = (count == CAP);
  assign do_pop   = pop && head_vld;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

module scancode_stream_decoder #(
  parameter int DATA_W     = 6,
  parameter int DEPTH      = 4,
  parameter int EMIT_BREAK = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              code_valid,
  input  logic [7:0]        code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_break,
  output logic              out_ext,
  output logic              out_shift,
  output logic              overflow,
  output logic              unknown
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  typedef struct packed {
    logic              brk;
    logic              ext;
    logic              shift;
    logic [DATA_W-1:0] code;
  } evt_t;

  state_t     state;
  state_t     state_nxt;
  logic       shift_l;
  logic       shift_r;
  logic       in_ext;
  logic       in_brk;
  logic       is_prefix;
  logic       is_ignored;
  logic       key_byte;
  logic       shift_key;
  logic [5:0] key_code;
  logic       evt_push;
  logic       evt_unknown;
  logic       pop;
  logic       fifo_full;
  evt_t       push_evt;
  evt_t       head_evt;

  function automatic logic [5:0] set2_map(input logic [7:0] b);
    case (b)
      8'h1C: set2_map = 6'd1;   8'h32: set2_map = 6'd2;   8'h21: set2_map = 6'd3;
      8'h23: set2_map = 6'd4;   8'h24: set2_map = 6'd5;   8'h2B: set2_map = 6'd6;
      8'h34: set2_map = 6'd7;   8'h33: set2_map = 6'd8;   8'h43: set2_map = 6'd9;
      8'h3B: set2_map = 6'd10;  8'h42: set2_map = 6'd11;  8'h4B: set2_map = 6'd12;
      8'h3A: set2_map = 6'd13;  8'h31: set2_map = 6'd14;  8'h44: set2_map = 6'd15;
      8'h4D: set2_map = 6'd16;  8'h15: set2_map = 6'd17;  8'h2D: set2_map = 6'd18;
      8'h1B: set2_map = 6'd19;  8'h2C: set2_map = 6'd20;  8'h3C: set2_map = 6'd21;
      8'h2A: set2_map = 6'd22;  8'h1D: set2_map = 6'd23;  8'h22: set2_map = 6'd24;
      8'h35: set2_map = 6'd25;  8'h1A: set2_map = 6'd26;  8'h45: set2_map = 6'd27;
      8'h16: set2_map = 6'd28;  8'h1E: set2_map = 6'd29;  8'h26: set2_map = 6'd30;
      8'h25: set2_map = 6'd31;  8'h2E: set2_map = 6'd32;  8'h36: set2_map = 6'd33;
      8'h3D: set2_map = 6'd34;  8'h3E: set2_map = 6'd35;  8'h46: set2_map = 6'd36;
      8'h29: set2_map = 6'd37;  8'h5A: set2_map = 6'd38;  8'h66: set2_map = 6'd39;
      default: set2_map = 6'd0;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (code_valid) begin
      if (code == 8'hE0) begin
        state_nxt = EXT;
      end else if (code == 8'hF0) begin
        if (state == IDLE) begin
          state_nxt = BRK;
        end else if (state == EXT) begin
          state_nxt = EXT_BRK;
        end
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    in_ext      = (state == EXT) || (state == EXT_BRK);
    in_brk      = (state == BRK) || (state == EXT_BRK);
    is_prefix   = (code == 8'hE0) || (code == 8'hF0);
    is_ignored  = code inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00};
    key_byte    = code_valid && !is_prefix && !is_ignored;
    shift_key   = !in_ext && ((code == 8'h12) || (code == 8'h59));
    // Keypad enter is the only extended key this block understands.
    key_code    = in_ext ? ((code == 8'h5A) ? 6'd38 : 6'd0) : set2_map(code);
    evt_unknown = key_byte && !shift_key && (key_code == 6'd0);
    evt_push    = key_byte && !shift_key && (key_code != 6'd0) &&
                  (!in_brk || (EMIT_BREAK != 0));
    push_evt.brk   = in_brk;
    push_evt.ext   = in_ext;
    push_evt.shift = shift_l || shift_r;
    push_evt.code  = DATA_W'(key_code);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shift_l  <= 1'b0;
      shift_r  <= 1'b0;
      unknown  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (key_byte && shift_key) begin
        if (code == 8'h12) begin
          shift_l <= !in_brk;
        end else begin
          shift_r <= !in_brk;
        end
      end
      unknown <= evt_unknown;
      if (evt_push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign pop = out_valid && out_ready;

  scancode_fifo #(
    .WIDTH($bits(evt_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (evt_push),
    .push_dat(push_evt),
    .pop     (pop),
    .head_vld(out_valid),
    .head_dat(head_evt),
    .full    (fifo_full)
  );

  assign out_data  = head_evt.code;
  assign out_break = head_evt.brk;
  assign out_ext   = head_evt.ext;
  assign out_shift = head_evt.shift;
endmodule

// File: tb/tb_scancode_stream_decoder.sv
// Bench for scancode_stream_decoder: two instances (make-only, and break-emitting with a wider code) share one stimulus stream.
module tb_scancode_stream_decoder;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       out_ready = 1'b0;

  logic       a_valid, a_break, a_ext, a_shift, a_ovf, a_unk;
  logic [5:0] a_data;
  logic       b_valid, b_break, b_ext, b_shift, b_ovf, b_unk;
  logic [7:0] b_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int code;
    bit brk;
    bit ext;
    bit shift;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  bit  m_ext, m_brk, m_lsh, m_rsh, ovf_a, ovf_b, unk_exp;

  // Scan byte for key code i+1
  logic [7:0] keys [39] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26,
    8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h29, 8'h5A, 8'h66};
  logic [7:0] ign [5] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00};

  always #5 clock = ~clock;

  scancode_stream_decoder #(.DATA_W(6), .DEPTH(4), .EMIT_BREAK(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .code_valid(code_valid), .code(code),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data),
    .out_break(a_break), .out_ext(a_ext), .out_shift(a_shift),
    .overflow(a_ovf), .unknown(a_unk));

  scancode_stream_decoder #(.DATA_W(8), .DEPTH(4), .EMIT_BREAK(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .code_valid(code_valid), .code(code),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
    .out_break(b_break), .out_ext(b_ext), .out_shift(b_shift),
    .overflow(b_ovf), .unknown(b_unk));

  function automatic int lookup(input logic [7:0] b, input bit ext);
    if (ext) return (b == 8'h5A) ? 38 : 0;
    for (int i = 0; i < 39; i++) begin
      if (keys[i] == b) return i + 1;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input bit v, input logic [7:0] b, input bit rdy);
    ev_t ev;
    int  c;
    bit  ext, brk, sh;
    if (rdy && qa.size() > 0) qa.delete(0);
    if (rdy && qb.size() > 0) qb.delete(0);
    unk_exp = 1'b0;
    if (!v) return;
    if (b == 8'hE0) begin
      m_ext = 1'b1;
      m_brk = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00}) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      ext = m_ext;
      brk = m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
      sh = m_lsh | m_rsh;
      if (!ext && b == 8'h12) begin
        m_lsh = !brk;
      end else if (!ext && b == 8'h59) begin
        m_rsh = !brk;
      end else begin
        c = lookup(b, ext);
        if (c == 0) begin
          unk_exp = 1'b1;
        end else begin
          ev = '{code: c, brk: brk, ext: ext, shift: sh};
          if (!brk) begin
            if (qa.size() < 4) qa.push_back(ev);
            else ovf_a = 1'b1;
          end
          if (qb.size() < 4) qb.push_back(ev);
          else ovf_b = 1'b1;
        end
      end
    end
  endtask

  task automatic compare();
    check("a_valid", 32'(a_valid), 32'(qa.size() > 0));
    if (qa.size() > 0) begin
      check("a_data", 32'(a_data), qa[0].code);
      check("a_break", 32'(a_break), 32'(qa[0].brk));
      check("a_ext", 32'(a_ext), 32'(qa[0].ext));
      check("a_shift", 32'(a_shift), 32'(qa[0].shift));
    end
    check("a_overflow", 32'(a_ovf), 32'(ovf_a));
    check("a_unknown", 32'(a_unk), 32'(unk_exp));
    check("b_valid", 32'(b_valid), 32'(qb.size() > 0));
    if (qb.size() > 0) begin
      check("b_data", 32'(b_data), qb[0].code);
      check("b_break", 32'(b_break), 32'(qb[0].brk));
      check("b_ext", 32'(b_ext), 32'(qb[0].ext));
      check("b_shift", 32'(b_shift), 32'(qb[0].shift));
    end
    check("b_overflow", 32'(b_ovf), 32'(ovf_b));
    check("b_unknown", 32'(b_unk), 32'(unk_exp));
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit rdy);
    code_valid = v;
    code       = b;
    out_ready  = rdy;
    model_byte(v, b, rdy);
    @(posedge clock);
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    code_valid = 1'b0;
    code       = 8'h00;
    out_ready  = 1'b0;
    @(posedge clock);
    #1;
    m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0;
    ovf_a = 0; ovf_b = 0; unk_exp = 0;
    qa.delete();
    qb.delete();
    check("rst_a_valid", 32'(a_valid), 0);
    check("rst_a_data", 32'(a_data), 0);
    check("rst_a_flags", 32'({a_break, a_ext, a_shift}), 0);
    check("rst_a_ovf_unk", 32'({a_ovf, a_unk}), 0);
    check("rst_b_valid", 32'(b_valid), 0);
    check("rst_b_data", 32'(b_data), 0);
    check("rst_b_flags", 32'({b_break, b_ext, b_shift}), 0);
    check("rst_b_ovf_unk", 32'({b_ovf, b_unk}), 0);
    reset_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] rb;
    int         r;

    do_reset();

    // Back-to-back makes, one-cycle latency
    step(1, 8'h1C, 0);
    step(1, 8'h1B, 0);
    drain(3);

    // Shift held across make and break
    step(1, 8'h12, 0); step(1, 8'h1C, 0); step(1, 8'hF0, 0); step(1, 8'h1C, 0);
    step(1, 8'hF0, 0); step(1, 8'h12, 0); step(1, 8'h1C, 0);
    drain(4);

    // Keypad enter make/break, then an unmapped extended key
    step(1, 8'hE0, 0); step(1, 8'h5A, 0); step(1, 8'hE0, 0); step(1, 8'hF0, 0);
    step(1, 8'h5A, 0); step(1, 8'hE0, 0); step(1, 8'h75, 0);
    drain(4);

    // Fill past capacity, then push and pop together while full
    for (int i = 0; i < 6; i++) step(1, 8'h1C, 0);
    step(1, 8'h32, 1);
    drain(5);

    // Pending break prefix discarded by reset
    step(1, 8'hF0, 0);
    do_reset();
    step(1, 8'h1C, 0);
    drain(2);

    // Ignored bytes interleaved with a make, and clearing a pending prefix
    step(1, 8'hAA, 0); step(1, 8'h1C, 0); step(1, 8'hFA, 0); step(1, 8'h00, 0);
    step(1, 8'hF0, 0); step(1, 8'hEE, 0); step(1, 8'h24, 0);
    drain(3);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        2: rb = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        3: rb = ign[$urandom_range(0, 4)];
        4: rb = 8'($urandom);
        default: rb = keys[$urandom_range(0, 38)];
      endcase
      step($urandom_range(0, 3) != 0, rb, $urandom_range(0, 2) != 0);
      if (i == 400) do_reset();
    end
    drain(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
